// File: rtl/wb_store_unit.sv
// Write-back stage: retires register-file writes and buffers stores in an in-order
// queue that drains to word-addressed memory over a req/ack write port.
module wb_store_unit #(
  parameter int SQ_DEPTH = 4,
  parameter int MEM_AW   = 10,
  parameter int DATA_W   = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              in_is_store,
  input  logic [4:0]                        in_rd,
  input  logic [DATA_W-1:0]                 in_data,
  input  logic [31:0]                       in_addr,
  input  logic [1:0]                        in_size,
  output logic                              rf_we,
  output logic [4:0]                        rf_waddr,
  output logic [DATA_W-1:0]                 rf_wdata,
  output logic                              mem_req,
  output logic [MEM_AW-1:0]                 mem_addr,
  output logic [DATA_W-1:0]                 mem_wdata,
  output logic [3:0]                        mem_be,
  input  logic                              mem_ack,
  output logic [$clog2(SQ_DEPTH+1)-1:0]     sq_count,
  output logic                              misalign_err,
  input  logic [31:0]                       probe_addr,
  output logic                              probe_hit
);

  localparam int PTR_W = $clog2(SQ_DEPTH);
  localparam int CNT_W = $clog2(SQ_DEPTH+1);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [MEM_AW-1:0]   sq_addr_q  [SQ_DEPTH];
  logic [DATA_W-1:0]   sq_wdata_q [SQ_DEPTH];
  logic [3:0]          sq_be_q    [SQ_DEPTH];

  logic                rf_we_q, misalign_q, mem_req_q;
  logic [4:0]          rf_waddr_q;
  logic [DATA_W-1:0]   rf_wdata_q, mem_wdata_q;
  logic [MEM_AW-1:0]   mem_addr_q;
  logic [3:0]          mem_be_q;

  logic                accept, enq, pop, load;
  logic                st_ok;
  logic [DATA_W-1:0]   st_wdata;
  logic [3:0]          st_be;
  logic [SQ_DEPTH-1:0] hit_vec;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^{in_addr[31:MEM_AW+2], probe_addr[31:MEM_AW+2], probe_addr[1:0]};

  // Readiness looks only at the registered count so it never depends on mem_ack.
  assign in_ready = reset && (count_q < CNT_W'(SQ_DEPTH));
  assign accept   = in_valid && in_ready;

  always_comb begin
    st_ok    = 1'b0;
    st_wdata = in_data;
    st_be    = 4'b0000;
    case (in_size)
      2'b00: begin
        st_ok    = 1'b1;
        st_wdata = {4{in_data[7:0]}};
        st_be    = 4'b0001 << in_addr[1:0];
      end
      2'b01: begin
        st_ok    = ~in_addr[0];
        st_wdata = {2{in_data[15:0]}};
        st_be    = in_addr[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        st_ok    = (in_addr[1:0] == 2'b00);
        st_be    = 4'b1111;
      end
      default: st_ok = 1'b0;
    endcase
  end

  assign enq = accept && in_is_store && st_ok;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      misalign_q <= 1'b0;
    end else begin
      rf_we_q    <= accept && !in_is_store && (in_rd != 5'd0);
      misalign_q <= accept && in_is_store && !st_ok;
      if (accept && !in_is_store) begin
        rf_waddr_q <= in_rd;
        rf_wdata_q <= in_data;
      end
    end
  end

  // Queue storage carries no reset; occupancy is defined purely by count and pointers.
  always_ff @(posedge clk) begin
    if (enq) begin
      sq_addr_q[wr_ptr_q]  <= in_addr[MEM_AW+1:2];
      sq_wdata_q[wr_ptr_q] <= st_wdata;
      sq_be_q[wr_ptr_q]    <= st_be;
    end
  end

  assign count_d = count_q + CNT_W'(enq) - CNT_W'(pop);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q <= count_d;
      if (enq) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (count_q != '0) state_d = S_REQ;
      S_REQ:   if (mem_ack)       state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    load = (state_q == S_IDLE) && (count_q != '0);
    pop  = (state_q == S_REQ) && mem_ack;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else if (load) begin
      mem_req_q   <= 1'b1;
      mem_addr_q  <= sq_addr_q[rd_ptr_q];
      mem_wdata_q <= sq_wdata_q[rd_ptr_q];
      mem_be_q    <= sq_be_q[rd_ptr_q];
    end else if (pop) begin
      mem_req_q   <= 1'b0;
    end
  end

  // An entry is live when its distance from the head is below the occupancy.
  for (genvar gi = 0; gi < SQ_DEPTH; gi++) begin : g_probe
    logic [PTR_W-1:0] offset;
    assign offset      = PTR_W'(gi) - rd_ptr_q;
    assign hit_vec[gi] = (CNT_W'(offset) < count_q) &&
                         (sq_addr_q[gi] == probe_addr[MEM_AW+1:2]);
  end

  assign probe_hit    = |hit_vec;
  assign sq_count     = count_q;
  assign rf_we        = rf_we_q;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;
  assign misalign_err = misalign_q;
  assign mem_req      = mem_req_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_be       = mem_be_q;

endmodule

// File: tb/tb_wb_store_unit.sv
// Bench for wb_store_unit: directed scenarios plus random traffic checked against
// a queue-based model of the store buffer and write-back outputs.
module tb_wb_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_is_store;
  logic [4:0]  in_rd;
  logic [31:0] in_data, in_addr;
  logic [1:0]  in_size;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        mem_req;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [2:0]  sq_count;
  logic        misalign_err;
  logic [31:0] probe_addr;
  logic        probe_hit;

  always #5 clk = ~clk;

  wb_store_unit dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_is_store(in_is_store),
    .in_rd(in_rd), .in_data(in_data), .in_addr(in_addr), .in_size(in_size),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .sq_count(sq_count), .misalign_err(misalign_err),
    .probe_addr(probe_addr), .probe_hit(probe_hit)
  );

  typedef struct packed {
    logic [9:0]  a;
    logic [31:0] d;
    logic [3:0]  be;
  } st_t;

  st_t         q[$];
  bit          e_req, e_rfwe, e_mis;
  logic [4:0]  e_rd;
  logic [31:0] e_rdat;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic bit align(input logic [31:0] addr, input logic [31:0] data,
                               input logic [1:0] size, output st_t e);
    e.a  = addr[11:2];
    e.d  = data;
    e.be = 4'b0000;
    case (size)
      2'd0: begin e.d = {4{data[7:0]}}; e.be = 4'b0001 << addr[1:0]; return 1'b1; end
      2'd1: begin e.d = {2{data[15:0]}}; e.be = addr[1] ? 4'b1100 : 4'b0011; return addr[0] == 1'b0; end
      2'd2: begin e.be = 4'b1111; return addr[1:0] == 2'b00; end
      default: return 1'b0;
    endcase
  endfunction

  // One clock: compare outputs mid-cycle, then advance the model across the edge.
  task automatic cycle();
    bit  acc, pop, ok, hit, nreq;
    st_t e;
    @(negedge clk);
    check("in_ready", 32'(in_ready), 32'(reset && q.size() < 4));
    check("sq_count", 32'(sq_count), 32'(q.size()));
    check("mem_req", 32'(mem_req), 32'(e_req));
    if (e_req && q.size() > 0) begin
      check("mem_addr", 32'(mem_addr), 32'(q[0].a));
      check("mem_wdata", mem_wdata, q[0].d);
      check("mem_be", 32'(mem_be), 32'(q[0].be));
    end
    check("rf_we", 32'(rf_we), 32'(e_rfwe));
    if (e_rfwe) begin
      check("rf_waddr", 32'(rf_waddr), 32'(e_rd));
      check("rf_wdata", rf_wdata, e_rdat);
    end
    check("misalign_err", 32'(misalign_err), 32'(e_mis));
    hit = 1'b0;
    foreach (q[i]) if (q[i].a == probe_addr[11:2]) hit = 1'b1;
    check("probe_hit", 32'(probe_hit), 32'(hit));
    acc = in_valid && reset && q.size() < 4;
    pop = e_req && mem_ack;
    ok  = align(in_addr, in_data, in_size, e);
    @(posedge clk);
    if (!reset) begin
      q.delete();
      e_req = 1'b0; e_rfwe = 1'b0; e_mis = 1'b0;
    end else begin
      nreq = e_req ? !mem_ack : (q.size() > 0);
      if (pop) void'(q.pop_front());
      if (acc && in_is_store && ok) q.push_back(e);
      e_rfwe = acc && !in_is_store && in_rd != 5'd0;
      if (acc && !in_is_store) begin e_rd = in_rd; e_rdat = in_data; end
      e_mis = acc && in_is_store && !ok;
      e_req = nreq;
    end
    #1;
  endtask

  task automatic put(input bit v, input bit st, input logic [4:0] rd,
                     input logic [31:0] d, input logic [31:0] a, input logic [1:0] sz);
    in_valid = v; in_is_store = st; in_rd = rd; in_data = d; in_addr = a; in_size = sz;
  endtask

  task automatic idle(input int n);
    put(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 2'd0);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    reset = 1'b0; mem_ack = 1'b0; probe_addr = 32'hFFFF_FFFF;
    e_req = 1'b0; e_rfwe = 1'b0; e_mis = 1'b0; e_rd = '0; e_rdat = '0;
    put(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 2'd0);
    cycle(); cycle();
    reset = 1'b1;
    check("rst_rf_waddr", 32'(rf_waddr), 32'd0);
    check("rst_rf_wdata", rf_wdata, 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_be", 32'(mem_be), 32'd0);

    // register writes, rd=5 then rd=0
    put(1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 32'd0, 2'd2); cycle();
    check("t1_rf_we", 32'(rf_we), 32'd1);
    check("t1_rf_wdata", rf_wdata, 32'hDEADBEEF);
    idle(1);
    put(1'b1, 1'b0, 5'd0, 32'h12345678, 32'd0, 2'd2); cycle();
    check("t1_rd0_we", 32'(rf_we), 32'd0);
    idle(1);

    // word store with delayed ack
    put(1'b1, 1'b1, 5'd0, 32'h55555555, 32'h10, 2'd2); cycle();
    idle(1);
    check("t2_mem_req", 32'(mem_req), 32'd1);
    check("t2_mem_addr", 32'(mem_addr), 32'd4);
    check("t2_mem_be", 32'(mem_be), 32'hF);
    idle(2);
    mem_ack = 1'b1; idle(1); mem_ack = 1'b0;
    check("t2_req_low", 32'(mem_req), 32'd0);
    check("t2_count", 32'(sq_count), 32'd0);
    idle(1);

    // byte and half lane replication
    put(1'b1, 1'b1, 5'd0, 32'h000000AB, 32'h13, 2'd0); cycle();
    idle(1);
    check("t3_byte_wdata", mem_wdata, 32'hABABABAB);
    check("t3_byte_be", 32'(mem_be), 32'h8);
    mem_ack = 1'b1; idle(1); mem_ack = 1'b0;
    put(1'b1, 1'b1, 5'd0, 32'h00001234, 32'h16, 2'd1); cycle();
    idle(1);
    check("t3_half_wdata", mem_wdata, 32'h12341234);
    check("t3_half_be", 32'(mem_be), 32'hC);
    mem_ack = 1'b1; idle(1); mem_ack = 1'b0;
    idle(1);

    // fill the queue with the memory stalled
    for (int i = 0; i < 4; i++) begin
      put(1'b1, 1'b1, 5'd0, 32'hA000_0000 + 32'(i), 32'(i * 4), 2'd2); cycle();
    end
    put(1'b1, 1'b1, 5'd0, 32'hBAD0_0000, 32'h40, 2'd2); cycle();
    check("t4_full_count", 32'(sq_count), 32'd4);
    check("t4_full_ready", 32'(in_ready), 32'd0);
    put(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 2'd0);
    probe_addr = 32'h0A; #1;
    check("t4_probe_hit", 32'(probe_hit), 32'd1);
    probe_addr = 32'h14; #1;
    check("t4_probe_miss", 32'(probe_hit), 32'd0);
    mem_ack = 1'b1; idle(10); mem_ack = 1'b0;
    check("t4_drained", 32'(sq_count), 32'd0);

    // misaligned half and word stores
    put(1'b1, 1'b1, 5'd0, 32'h1111, 32'h11, 2'd1); cycle();
    check("t5_mis_half", 32'(misalign_err), 32'd1);
    put(1'b1, 1'b1, 5'd0, 32'h2222, 32'h02, 2'd2); cycle();
    check("t5_mis_word", 32'(misalign_err), 32'd1);
    idle(3);
    check("t5_no_req", 32'(mem_req), 32'd0);

    // reset while a request is outstanding
    put(1'b1, 1'b1, 5'd0, 32'h1, 32'h20, 2'd2); cycle();
    put(1'b1, 1'b1, 5'd0, 32'h2, 32'h24, 2'd2); cycle();
    idle(1);
    reset = 1'b0; idle(1); reset = 1'b1;
    check("t6_req_cleared", 32'(mem_req), 32'd0);
    check("t6_count_cleared", 32'(sq_count), 32'd0);
    idle(5);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      put($urandom_range(0, 1) == 1, $urandom_range(0, 9) < 6, 5'($urandom_range(0, 31)),
          $urandom, 32'(($urandom_range(0, 3) << 12) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3)),
          2'($urandom_range(0, 3)));
      if ($urandom_range(0, 4) == 0) in_size = 2'd2;
      if (in_size == 2'd2 && $urandom_range(0, 1) == 1) in_addr[1:0] = 2'b00;
      mem_ack    = $urandom_range(0, 9) < 4;
      probe_addr = 32'(($urandom_range(0, 3) << 12) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
      reset      = $urandom_range(0, 199) != 0;
      cycle();
    end
    reset = 1'b1; mem_ack = 1'b1;
    idle(10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
